// File: rtl/ctrl_contador_pkg.sv
// ctrl_contador_pkg: state encodings and counter control codes shared by the arbiter files.
package ctrl_contador_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam logic [1:0] X_HOLD = 2'b00;
  localparam logic [1:0] X_UP   = 2'b01;
  localparam logic [1:0] X_DOWN = 2'b10;
endpackage

// File: rtl/arb_sel_2.sv
// arb_sel_2: two-requester winner select; round-robin on last under ARB_ROUND_ROBIN_EN, else fixed priority to 0.
module arb_sel_2 (
  input  logic [1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       last,
`endif
  output logic       win
);
`ifdef ARB_ROUND_ROBIN_EN
  always_comb win = &req ? ~last : req[1];
`else
  always_comb win = ~req[0] & req[1];
`endif
endmodule

// File: rtl/ctrl_arbitro_contador.sv
// ctrl_arbitro_contador: two-requester arbiter driving N up/down steps on a shared 2-bit counter.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; default build is fixed priority to requester 0.
module ctrl_arbitro_contador
  import ctrl_contador_pkg::*;
#(
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [1:0]        Req,
  input  logic              Dir0,
  input  logic              Dir1,
  input  logic [STEP_W-1:0] Pasos0,
  input  logic [STEP_W-1:0] Pasos1,
  output logic [1:0]        Gnt,
  output logic [1:0]        Done,
  output logic              Busy,
  output logic [1:0]        X,
  output logic              En
);
  state_t state, state_n;
  logic [1:0] gnt;
  logic dir_r, win, win_dir, abort;
  logic [STEP_W-1:0] rem, win_pasos;
`ifdef ARB_ROUND_ROBIN_EN
  logic last;
  arb_sel_2 u_sel (.req(Req), .last(last), .win(win));
`else
  arb_sel_2 u_sel (.req(Req), .win(win));
`endif
  assign win_dir   = win ? Dir1 : Dir0;
  assign win_pasos = win ? Pasos1 : Pasos0;
  // only the granted requester's Req is watched once the run has started
  assign abort = (state == ST_RUN) && ((Req & gnt) == 2'b00);
  always_ff @(posedge Clk)
    state <= Rst ? ST_IDLE : state_n;
  always_comb
    state_n = state == ST_IDLE ? (|Req ? (win_pasos == '0 ? ST_DONE : ST_RUN) : ST_IDLE)
            : state == ST_RUN  ? (abort ? ST_IDLE : (rem == STEP_W'(1) ? ST_DONE : ST_RUN))
            : ST_IDLE;
  always_ff @(posedge Clk)
    if (Rst) begin
      gnt   <= '0;
      rem   <= '0;
      dir_r <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last  <= 1'b1;
`endif
    end else if (state == ST_IDLE && |Req) begin
      gnt   <= win ? 2'b10 : 2'b01;
      rem   <= win_pasos;
      dir_r <= win_dir;
    end else if (abort || state == ST_DONE) begin
      gnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last  <= gnt[1];
`endif
    end else if (state == ST_RUN) begin
      rem   <= rem - STEP_W'(1);
    end
  always_comb begin
    Gnt  = gnt;
    Busy = state != ST_IDLE;
    En   = state == ST_RUN;
    X    = state == ST_RUN ? (dir_r ? X_UP : X_DOWN) : X_HOLD;
    Done = state == ST_DONE ? gnt : 2'b00;
  end
endmodule

// File: tb/tb_ctrl_arbitro_contador.sv
// tb_ctrl_arbitro_contador: randomized bench against a run-length reference model of the arbiter.
module tb_ctrl_arbitro_contador;
  localparam int STEP_W = 4;
  logic Clk = 1'b0, Rst = 1'b1;
  logic [1:0] Req = 2'b11;
  logic Dir0 = 1'b1, Dir1 = 1'b0;
  logic [STEP_W-1:0] Pasos0 = 4'd2, Pasos1 = 4'd2;
  logic [1:0] Gnt, Done, X;
  logic Busy, En;
  int n_cmp = 0, n_bad = 0;
  int m_owner = -1, m_left = 0, m_dir = 0, m_last = 1;
  int cyc = 0, en_seen = 0, done_at = -1, gprev = 0, cnt = 0, mcnt = 0, c0;
  int done_seen[2] = '{0, 0};
  int gq[$];
  int exp_order[4];
  always #5 Clk = ~Clk;
  ctrl_arbitro_contador #(.STEP_W(STEP_W)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Dir0(Dir0), .Dir1(Dir1),
    .Pasos0(Pasos0), .Pasos1(Pasos1), .Gnt(Gnt), .Done(Done),
    .Busy(Busy), .X(X), .En(En)
  );
  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask
  function automatic int pick(input logic [1:0] r);
`ifdef ARB_ROUND_ROBIN_EN
    return r == 2'b11 ? 1 - m_last : (r[1] ? 1 : 0);
`else
    return r[0] ? 0 : 1;
`endif
  endfunction
  // model: owner of the counter plus the number of En cycles still owed; zero owed means the Done cycle
  task automatic step();
    int e_busy, e_gnt, e_en, e_x, e_done;
    e_busy = int'(m_owner >= 0);
    e_gnt  = e_busy != 0 ? (1 << m_owner) : 0;
    e_en   = int'(e_busy != 0 && m_left > 0);
    e_x    = e_en != 0 ? (m_dir != 0 ? 1 : 2) : 0;
    e_done = (e_busy != 0 && m_left == 0) ? e_gnt : 0;
    check("gnt", int'(Gnt), e_gnt);
    check("done", int'(Done), e_done);
    check("busy", int'(Busy), e_busy);
    check("x", int'(X), e_x);
    check("en", int'(En), e_en);
    if (e_done != 0) check("cnt", cnt, mcnt);
    if (En) begin
      en_seen++;
      cnt = X == 2'b01 ? (cnt + 1) % 4 : (X == 2'b10 ? (cnt + 3) % 4 : cnt);
    end
    if (e_en != 0) mcnt = m_dir != 0 ? (mcnt + 1) % 4 : (mcnt + 3) % 4;
    for (int i = 0; i < 2; i++) if (Done[i]) begin done_seen[i]++; done_at = cyc; end
    if (Gnt != 2'b00 && gprev == 0) gq.push_back(int'(Gnt[1]));
    gprev = int'(Gnt);
    if (Rst) begin
      m_owner = -1; m_left = 0; m_dir = 0; m_last = 1;
    end else if (m_owner < 0) begin
      if (Req != 2'b00) begin
        m_owner = pick(Req);
        m_left  = m_owner != 0 ? int'(Pasos1) : int'(Pasos0);
        m_dir   = m_owner != 0 ? int'(Dir1) : int'(Dir0);
      end
    end else if (m_left > 0) begin
      if (!Req[m_owner]) begin m_last = m_owner; m_owner = -1; end
      else m_left--;
    end else begin
      m_last = m_owner; m_owner = -1;
    end
    cyc++;
    @(negedge Clk);
  endtask
  task automatic settle();
    for (int k = 0; k < 40 && m_owner >= 0; k++) step();
    check("idle_timeout", m_owner, -1);
  endtask
  function automatic logic [STEP_W-1:0] rnd_pasos();
    return STEP_W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 4));
  endfunction
  task automatic agent(input int i);
    logic fresh;
    fresh = 1'b0;
    if (Req[i]) begin
      if (m_owner == i && m_left == 0) begin Req[i] = ($urandom_range(0, 3) == 0); fresh = Req[i]; end
      else if (m_owner == i && $urandom_range(0, 15) == 0) Req[i] = 1'b0;
    end else begin
      Req[i] = ($urandom_range(0, 2) == 0);
      fresh = Req[i];
    end
    if (Req[i] && (fresh || $urandom_range(0, 3) == 0)) begin
      if (i == 0) begin Dir0 = 1'($urandom); Pasos0 = rnd_pasos(); end
      else begin Dir1 = 1'($urandom); Pasos1 = rnd_pasos(); end
    end
  endtask
  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    @(negedge Clk);
    step();
    step();
    Rst = 1'b0;
    gq.delete();
    step();
    check("first_gnt", int'(Gnt), 1);
    repeat (15) step();
    check("order_len", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++) check($sformatf("order%0d", k), gq[k], exp_order[k]);
    Req = 2'b00;
    settle();
    step();
    cnt = 2; mcnt = 2; en_seen = 0; done_seen = '{0, 0};
    Req = 2'b01; Dir0 = 1'b1; Pasos0 = 4'd5;
    c0 = cyc;
    for (int k = 0; k < 15 && done_seen[0] == 0; k++) step();
    Req = 2'b00;
    check("up_done_lat", done_at - c0, 6);
    check("up_en_cycles", en_seen, 5);
    check("up_final_cnt", cnt, 3);
    step();
    check("up_done_once", done_seen[0], 1);
    en_seen = 0; done_seen = '{0, 0};
    Req = 2'b10; Dir1 = 1'b0; Pasos1 = 4'd0;
    c0 = cyc;
    for (int k = 0; k < 10 && done_seen[1] == 0; k++) step();
    Req = 2'b00;
    check("zero_done_lat", done_at - c0, 1);
    check("zero_en_cycles", en_seen, 0);
    settle();
    step();
    en_seen = 0; done_seen = '{0, 0};
    Req = 2'b11; Dir0 = 1'b1; Pasos0 = 4'd8; Dir1 = 1'b0; Pasos1 = 4'd1;
    repeat (3) step();
    Req[0] = 1'b0;
    step();
    check("abort_en_cycles", en_seen, 3);
    check("abort_idle_gnt", int'(Gnt), 0);
    step();
    check("abort_next_gnt", int'(Gnt), 2);
    for (int k = 0; k < 10 && done_seen[1] == 0; k++) step();
    Req = 2'b00;
    check("abort_no_done0", done_seen[0], 0);
    check("abort_done1", done_seen[1], 1);
    settle();
    step();
    done_seen = '{0, 0};
    Req = 2'b01; Dir0 = 1'b0; Pasos0 = 4'd5;
    repeat (2) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0; Req = 2'b00;
    check("rst_run_en", int'(En), 0);
    check("rst_run_gnt", int'(Gnt), 0);
    repeat (3) step();
    check("rst_run_no_done", done_seen[0], 0);
    repeat (2000) begin
      Rst = ($urandom_range(0, 299) == 0);
      agent(0);
      agent(1);
      step();
    end
    Rst = 1'b0; Req = 2'b00;
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
